// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths and arbiter FSM states for the SDRAM arbiter
package sdram_pkg;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/sdram_id_fifo.sv
// sdram_id_fifo: in-order queue of master IDs for outstanding SDRAM reads
module sdram_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority video port plus round-robin masters onto one SDRAM controller
module sdram_arbiter import sdram_pkg::*; #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*MASK_W-1:0] m_wmask,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_req,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [MASK_W-1:0]             s_wmask,
    input  logic                          s_ack,
    input  logic                          s_rvalid,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic                          err_unexpected
);
    localparam int SW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    state_t                   state, state_nxt;
    logic [SW-1:0]            sel, rr_ptr, win, id_head;
    logic [NUM_MASTERS-1:0]   elig;
    logic                     any, grant, accept, push, pop, id_full, id_empty;
    logic [$clog2(ID_DEPTH):0] id_count;
    int                       idx;
    assign elig   = m_req & (m_write | {NUM_MASTERS{!id_full}});
    assign accept = state == ISSUE && s_ack;
    assign push   = accept && !s_write;
    assign pop    = s_rvalid && id_count != '0;
    // Master 0 preempts; otherwise scan 1..N-1 starting at rr_ptr
    always_comb begin
        win = '0;
        any = elig[0];
        idx = 0;
        for (int o = 0; o < NUM_MASTERS - 1; o++) begin
            idx = (int'(rr_ptr) - 1 + o) % (NUM_MASTERS - 1) + 1;
            if (!any && elig[idx]) begin
                win = SW'(idx);
                any = 1'b1;
            end
        end
    end
    always_comb begin
        grant     = state == IDLE && any;
        state_nxt = grant ? ISSUE : accept ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_req          <= 1'b0;
            s_write        <= 1'b0;
            s_addr         <= '0;
            s_wdata        <= '0;
            s_wmask        <= '0;
            sel            <= '0;
            rr_ptr         <= SW'(1);
            m_ack          <= '0;
            m_rvalid       <= '0;
            m_rdata        <= '0;
            err_unexpected <= 1'b0;
        end else begin
            m_ack    <= '0;
            m_rvalid <= '0;
            if (grant) begin
                s_req   <= 1'b1;
                s_write <= m_write[win];
                s_addr  <= m_addr[int'(win)*ADDR_W +: ADDR_W];
                s_wdata <= m_wdata[int'(win)*DATA_W +: DATA_W];
                s_wmask <= m_wmask[int'(win)*MASK_W +: MASK_W];
                sel     <= win;
                if (win != '0) rr_ptr <= (int'(win) == NUM_MASTERS - 1) ? SW'(1) : win + SW'(1);
            end
            if (accept) begin
                s_req      <= 1'b0;
                m_ack[sel] <= 1'b1;
            end
            if (pop) begin
                m_rvalid[id_head] <= 1'b1;
                m_rdata           <= s_rdata;
            end
            if (s_rvalid && id_empty) err_unexpected <= 1'b1;
        end
    end
    sdram_id_fifo #(.W(SW), .DEPTH(ID_DEPTH)) u_id_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (sel),
        .pop     (pop),
        .dout    (id_head),
        .count   (id_count),
        .full    (id_full),
        .empty   (id_empty)
    );
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of grant order, ID routing, stalls, errors and reset
module tb_sdram_arbiter;
    localparam int N = 4;
    logic           clock = 1'b0;
    logic           reset_n = 1'b1;
    logic [N-1:0]   m_req = '0, m_write = '0;
    logic [N*26-1:0] m_addr = '0;
    logic [N*32-1:0] m_wdata = '0;
    logic [N*4-1:0]  m_wmask = '0;
    logic [N-1:0]   m_ack, m_rvalid;
    logic [31:0]    m_rdata;
    logic           s_req, s_write;
    logic [25:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [3:0]     s_wmask;
    logic           s_ack = 1'b0, s_rvalid = 1'b0;
    logic [31:0]    s_rdata = '0;
    logic           err_unexpected;
    int passed = 0, fails = 0, total = 0;

    sdram_arbiter #(.NUM_MASTERS(N), .ID_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .m_req(m_req), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_ack(m_ack),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .s_req(s_req), .s_write(s_write),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_ack(s_ack),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err_unexpected(err_unexpected)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        m_req = '0; m_write = '0; s_ack = 0; s_rvalid = 0;
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
    endtask

    task automatic set_m(input int i, input logic req, input logic wr, input logic [25:0] addr);
        m_req[i] = req;
        m_write[i] = wr;
        m_addr[i*26 +: 26] = addr;
        m_wdata[i*32 +: 32] = 32'hC0DE0000 + i;
        m_wmask[i*4 +: 4] = 4'hF;
    endtask

    task automatic serve(input string tag, input logic [25:0] exp_addr, input logic [3:0] exp_ack);
        for (int n = 0; n < 20 && s_req !== 1'b1; n++) tick();
        check({tag, "_sreq"}, s_req, 1);
        check({tag, "_addr"}, s_addr, exp_addr);
        s_ack = 1;
        tick();
        s_ack = 0;
        check({tag, "_ack"}, m_ack, exp_ack);
    endtask

    initial begin
        #2 reset_n = 0;
        tick();
        check("rst_sreq", s_req, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_mack", m_ack, 0);
        check("rst_rvalid", m_rvalid, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_err", err_unexpected, 0);
        reset_n = 1;
        tick();

        // single read by master 2
        set_m(2, 1, 0, 26'h000100);
        tick();
        check("rd_sreq", s_req, 1);
        check("rd_saddr", s_addr, 26'h100);
        check("rd_swrite", s_write, 0);
        check("rd_swmask", s_wmask, 4'hF);
        tick();
        check("rd_hold_sreq", s_req, 1);
        check("rd_hold_addr", s_addr, 26'h100);
        s_ack = 1;
        tick();
        s_ack = 0;
        check("rd_mack", m_ack, 4'b0100);
        check("rd_sreq_clr", s_req, 0);
        m_req[2] = 0;
        tick();
        check("rd_mack_pulse", m_ack, 0);
        repeat (4) tick();
        check("rd_no_rvalid", m_rvalid, 0);
        s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        tick();
        s_rvalid = 0;
        check("rd_rvalid", m_rvalid, 4'b0100);
        check("rd_rdata", m_rdata, 32'hDEADBEEF);
        tick();
        check("rd_rvalid_pulse", m_rvalid, 0);
        check("rd_rdata_hold", m_rdata, 32'hDEADBEEF);

        // round robin among 1..3, then master 0 priority
        do_reset();
        for (int i = 1; i < 4; i++) set_m(i, 1, 1, 26'h1000 + 26'(i));
        serve("rr0", 26'h1001, 4'b0010);
        serve("rr1", 26'h1002, 4'b0100);
        serve("rr2", 26'h1003, 4'b1000);
        serve("rr3", 26'h1001, 4'b0010);
        serve("rr4", 26'h1002, 4'b0100);
        serve("rr5", 26'h1003, 4'b1000);
        set_m(0, 1, 1, 26'h1000);
        serve("pri0", 26'h1000, 4'b0001);
        serve("pri1", 26'h1000, 4'b0001);
        serve("pri2", 26'h1000, 4'b0001);
        m_req[0] = 0;
        serve("rr_keep", 26'h1001, 4'b0010);
        m_req = '0;

        // full ID FIFO blocks reads only
        do_reset();
        set_m(1, 1, 0, 26'h1001);
        serve("fill0", 26'h1001, 4'b0010);
        serve("fill1", 26'h1001, 4'b0010);
        serve("fill2", 26'h1001, 4'b0010);
        serve("fill3", 26'h1001, 4'b0010);
        set_m(3, 1, 1, 26'h1003);
        serve("full_wr", 26'h1003, 4'b1000);
        m_req[3] = 0;
        repeat (4) tick();
        check("full_stall", s_req, 0);
        s_rvalid = 1; s_rdata = 32'hA0;
        tick();
        s_rvalid = 0;
        check("full_pop_rvalid", m_rvalid, 4'b0010);
        check("full_pop_rdata", m_rdata, 32'hA0);
        serve("m1_resume", 26'h1001, 4'b0010);
        m_req = '0;

        // interleaved reads from masters 0 and 2 return in issue order
        do_reset();
        set_m(0, 1, 0, 26'h1000);
        serve("il0", 26'h1000, 4'b0001);
        m_req[0] = 0;
        set_m(2, 1, 0, 26'h1002);
        serve("il1", 26'h1002, 4'b0100);
        m_req[2] = 0;
        set_m(0, 1, 0, 26'h1000);
        serve("il2", 26'h1000, 4'b0001);
        m_req[0] = 0;
        s_rvalid = 1; s_rdata = 32'h11;
        tick();
        check("il_rv0", m_rvalid, 4'b0001);
        check("il_rd0", m_rdata, 32'h11);
        s_rdata = 32'h22;
        tick();
        check("il_rv1", m_rvalid, 4'b0100);
        check("il_rd1", m_rdata, 32'h22);
        s_rdata = 32'h33;
        tick();
        s_rvalid = 0;
        check("il_rv2", m_rvalid, 4'b0001);
        check("il_rd2", m_rdata, 32'h33);
        tick();
        check("il_err_clear", err_unexpected, 0);

        // unexpected return
        s_rvalid = 1; s_rdata = 32'h55;
        tick();
        s_rvalid = 0;
        check("unexp_rvalid", m_rvalid, 0);
        check("unexp_err", err_unexpected, 1);
        check("unexp_rdata_hold", m_rdata, 32'h33);
        repeat (3) tick();
        check("unexp_sticky", err_unexpected, 1);

        // reset during ISSUE with a read outstanding
        set_m(1, 1, 0, 26'h1001);
        serve("pre_rst", 26'h1001, 4'b0010);
        m_req[1] = 0;
        tick();
        set_m(3, 1, 0, 26'h1003);
        tick();
        check("issue_sreq", s_req, 1);
        reset_n = 0;
        #1;
        check("async_sreq", s_req, 0);
        check("async_err", err_unexpected, 0);
        m_req = '0;
        tick();
        reset_n = 1;
        tick();
        s_rvalid = 1; s_rdata = 32'h77;
        tick();
        s_rvalid = 0;
        check("rst_fifo_rvalid", m_rvalid, 0);
        check("rst_fifo_err", err_unexpected, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, 4, number of requesters; index 0 is the video (real-time) port.
REQ-002 Parameter ID_DEPTH, 4, number of outstanding reads tracked; power of two, at least 2.
REQ-003 clock  in  1  system clock; the block has one clock and reset is asynchronous and active-low.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 m_req  in  NUM_MASTERS  per-master request; held high until m_ack.
REQ-006 m_write  in  NUM_MASTERS  per-master 1=write, 0=read.
REQ-007 m_addr  in  NUM_MASTERSx26  per-master word address.
REQ-008 m_wdata  in  NUM_MASTERSx32  per-master write data.
REQ-009 m_wmask  in  NUM_MASTERSx4  per-master byte enables; 1 = write that byte.
REQ-010 m_ack  out  NUM_MASTERS  one-cycle pulse: request accepted by SDRAM controller.
REQ-011 m_rvalid  out  NUM_MASTERS  one-cycle pulse: m_rdata holds this master's read data.
REQ-012 m_rdata  out  32  read data, shared by all masters.
REQ-013 s_req  out  1  request to SDRAM controller.
REQ-014 s_write, s_addr, s_wdata, s_wmask  out  1/26/32/4  registered copy of the granted request.
REQ-015 s_ack  in  1  controller accepted s_req this cycle.
REQ-016 s_rvalid, s_rdata  in  1/32  controller read return, in issue order.
REQ-017 err_unexpected  out  1  sticky: s_rvalid arrived with no outstanding read.

Function
REQ-018 FSM states are IDLE, ISSUE and DONE.
REQ-019 IDLE: if any eligible m_req, latch the winner's fields into s_*, set s_req=1, record sel, go to ISSUE.
REQ-020 A master is eligible only if m_req=1 and either m_write=1 or the ID FIFO is not full.
REQ-021 Master 0 wins whenever it is eligible.
REQ-022 Otherwise masters 1..NUM_MASTERS-1 are served round-robin, starting from rr_ptr.
REQ-023 After granting master k (k≥1), rr_ptr becomes k+1, wrapping to 1.
REQ-024 Granting master 0 leaves rr_ptr unchanged.
REQ-025 ISSUE: s_* are held stable while s_ack=0.
REQ-026 On s_ack in ISSUE: s_req is cleared, and if s_write=0, sel is pushed into the ID FIFO.
REQ-027 On s_ack in ISSUE: m_ack[sel]=1 on the next cycle (DONE), and the FSM goes to DONE.
REQ-028 DONE lasts exactly one cycle and then returns to IDLE; m_req is not sampled in DONE.
REQ-029 Minimum request spacing is 3 cycles; grant latency from m_req in IDLE to s_req is 1 cycle.
REQ-030 On s_rvalid with FIFO non-empty: pop the head ID h.
REQ-031 The following cycle after that pop, m_rvalid[h]=1 and m_rdata=s_rdata (registered, 1-cycle latency).
REQ-032 A FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
REQ-033 Full (count==ID_DEPTH) blocks read grants only; writes proceed.
REQ-034 s_rvalid with the FIFO empty is discarded (no m_rvalid) and sets err_unexpected until reset.
REQ-035 m_rdata holds its last value when m_rvalid=0.

Reset
REQ-036 Reset values: FSM=IDLE, s_req=0, s_write=0, s_addr=0, s_wdata=0, s_wmask=0.
REQ-037 Reset values: m_ack=0, m_rvalid=0, m_rdata=0, err_unexpected=0, rr_ptr=1, FIFO empty.
REQ-038 Reset asserted mid-transaction drops s_req immediately and discards all outstanding IDs; the SDRAM controller is reset from the same reset_n.

Structure
REQ-039 Package sdram_pkg holds ADDR_W=26, DATA_W=32, MASK_W=4 and the FSM state enum.
REQ-040 The ID FIFO is a sub-module sdram_id_fifo: width clog2(NUM_MASTERS), depth ID_DEPTH, with count, full and empty outputs.

Verification
REQ-041 Master 2 reads address 0x000100, controller acks after 2 cycles and returns 0xDEADBEEF 5 cycles later -> m_ack[2] pulses once, then m_rvalid[2]=1 with m_rdata=0xDEADBEEF.
REQ-042 Masters 1, 2 and 3 request continuously -> grant order 1,2,3,1,2,3; with master 0 also requesting, master 0 wins every IDLE decision.
REQ-043 Master 1 issues 4 reads with no returns, then master 1 reads and master 3 writes -> master 3 is granted and master 1 stalls until the first s_rvalid.
REQ-044 Masters 0 and 2 issue interleaved reads, and data returns 0x11, 0x22, 0x33 -> each word goes to its issuing master in issue order.
REQ-045 s_rvalid with no outstanding read -> no m_rvalid, err_unexpected=1 and stays 1; reset_n low during ISSUE -> s_req=0 in the same cycle and the FIFO is empty.
